dual_core_reg_arbiter: RTL

- Arbitrates between two bus masters for the shared UART register file: core A (host EBI side) and core B (second core).
- Serialises single-word read/write transactions onto the register-file port: addr, we, re, write_data, read_data.
- Uses round-robin priority with an optional per-master lock for atomic read-modify-write sequences.
- Sits between the masters' bus interfaces and the register block. Only one transaction is in flight at a time.

---
 rtl/dual_core_reg_arbiter_if.sv | 43 ++++
 rtl/dual_core_reg_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/dual_core_reg_arbiter_if.sv
// Bundle of the two master request ports and the shared register-file port.
// Handshake: a master raises req with wr/lock/addr/wdata stable and keeps it
// high until its one-cycle ack; the arbiter owns the register-file side.
interface dual_core_reg_arbiter_if #(
  parameter int AW = 6,
  parameter int DW = 32
);
  logic          req_a;
  logic          req_b;
  logic          wr_a;
  logic          wr_b;
  logic          lock_a;
  logic          lock_b;
  logic [AW-1:0] addr_a;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] wdata_a;
  logic [DW-1:0] wdata_b;
  logic          ack_a;
  logic          ack_b;
  logic [DW-1:0] rdata_a;
  logic [DW-1:0] rdata_b;
  logic [AW-1:0] addr_o;
  logic          we_o;
  logic          re_o;
  logic [DW-1:0] wdata_o;
  logic [DW-1:0] rdata_i;
  logic          busy;
  logic          owner;

  modport slave (
    input  req_a, req_b, wr_a, wr_b, lock_a, lock_b,
    input  addr_a, addr_b, wdata_a, wdata_b, rdata_i,
    output ack_a, ack_b, rdata_a, rdata_b,
    output addr_o, we_o, re_o, wdata_o, busy, owner
  );

  modport master (
    output req_a, req_b, wr_a, wr_b, lock_a, lock_b,
    output addr_a, addr_b, wdata_a, wdata_b, rdata_i,
    input  ack_a, ack_b, rdata_a, rdata_b,
    input  addr_o, we_o, re_o, wdata_o, busy, owner
  );
endinterface

// File: rtl/dual_core_reg_arbiter.sv
// Round-robin arbiter with per-master lock that serialises single-word
// register-file transactions from two cores, one transaction in flight.
module dual_core_reg_arbiter #(
  parameter int AW     = 6,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  dual_core_reg_arbiter_if.slave  io_bus,
  output logic [1:0]              o_state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_ACK    = 2'd3
  } state_t;

  localparam logic [1:0] LP_WAIT_INIT = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

  state_t        r_state;
  logic          r_ptr;
  logic          r_lock_held;
  logic          r_wr;
  logic          r_lk;
  logic          r_owner;
  logic [1:0]    r_cnt;
  logic          r_ack_a;
  logic          r_ack_b;
  logic          r_we;
  logic          r_re;
  logic          r_busy;
  logic [AW-1:0] r_addr_o;
  logic [DW-1:0] r_wdata_o;
  logic [DW-1:0] r_rdata_a;
  logic [DW-1:0] r_rdata_b;

  logic          w_grant;
  logic          w_win;
  logic          w_win_wr;

  // While a lock is held the pointer names the lock owner, so only it may win.
  always_comb begin
    w_grant = 1'b0;
    w_win   = r_ptr;
    if (r_lock_held) begin
      w_grant = r_ptr ? io_bus.req_b : io_bus.req_a;
    end else if (io_bus.req_a && io_bus.req_b) begin
      w_grant = 1'b1;
    end else if (io_bus.req_a) begin
      w_grant = 1'b1;
      w_win   = 1'b0;
    end else if (io_bus.req_b) begin
      w_grant = 1'b1;
      w_win   = 1'b1;
    end
    w_win_wr = w_win ? io_bus.wr_b : io_bus.wr_a;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= 1'b0;
      r_lock_held <= 1'b0;
      r_wr        <= 1'b0;
      r_lk        <= 1'b0;
      r_owner     <= 1'b0;
      r_cnt       <= 2'd0;
      r_ack_a     <= 1'b0;
      r_ack_b     <= 1'b0;
      r_we        <= 1'b0;
      r_re        <= 1'b0;
      r_busy      <= 1'b0;
      r_addr_o    <= '0;
      r_wdata_o   <= '0;
      r_rdata_a   <= '0;
      r_rdata_b   <= '0;
    end else begin
      r_ack_a <= 1'b0;
      r_ack_b <= 1'b0;
      r_we    <= 1'b0;
      r_re    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_owner   <= w_win;
            r_wr      <= w_win_wr;
            r_lk      <= w_win ? io_bus.lock_b : io_bus.lock_a;
            r_addr_o  <= w_win ? io_bus.addr_b : io_bus.addr_a;
            r_wdata_o <= w_win ? io_bus.wdata_b : io_bus.wdata_a;
            r_we      <= w_win_wr;
            r_re      <= !w_win_wr;
            r_busy    <= 1'b1;
            r_state   <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (r_wr) begin
            r_ack_a <= !r_owner;
            r_ack_b <= r_owner;
            r_state <= S_ACK;
          end else if (RD_LAT == 0) begin
            if (r_owner) r_rdata_b <= io_bus.rdata_i;
            else         r_rdata_a <= io_bus.rdata_i;
            r_ack_a <= !r_owner;
            r_ack_b <= r_owner;
            r_state <= S_ACK;
          end else begin
            r_cnt   <= LP_WAIT_INIT;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == 2'd0) begin
            if (r_owner) r_rdata_b <= io_bus.rdata_i;
            else         r_rdata_a <= io_bus.rdata_i;
            r_ack_a <= !r_owner;
            r_ack_b <= r_owner;
            r_state <= S_ACK;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        S_ACK: begin
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
          r_lock_held <= r_lk;
          r_ptr       <= r_lk ? r_owner : !r_owner;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.ack_a   = r_ack_a;
  assign io_bus.ack_b   = r_ack_b;
  assign io_bus.rdata_a = r_rdata_a;
  assign io_bus.rdata_b = r_rdata_b;
  assign io_bus.addr_o  = r_addr_o;
  assign io_bus.we_o    = r_we;
  assign io_bus.re_o    = r_re;
  assign io_bus.wdata_o = r_wdata_o;
  assign io_bus.busy    = r_busy;
  assign io_bus.owner   = r_owner;
  assign o_state_dbg    = r_state;

endmodule
